// File: rtl/tpu_pkg.sv
// Shared state encoding, default widths and the accumulator-width helper
// for the matrix-vector engine.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int ARRAY_SIZE_DEF  = 8;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int OUT_WIDTH_DEF   = 16;
  localparam int K_MAX_DEF       = 8;
  localparam int W_ADDR_W_DEF    = 6;
  localparam int V_ADDR_W_DEF    = 5;
  localparam int O_ADDR_W_DEF    = 6;

  function automatic int acc_width(input int data_w, input int k_max);
    return 2 * data_w + $clog2(k_max) + 1;
  endfunction

endpackage

// File: rtl/tpu_mv_quantize.sv
// One-lane quantiser: round-half-up arithmetic right shift, then saturate
// (TPU_SAT_EN defined) or wrap to OUT_W bits (default).
module tpu_mv_quantize
  import tpu_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int OUT_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [4:0]       shift_i,
  output logic [OUT_W-1:0] q_o
);

  // Headroom so x + 2^30 can never overflow the intermediate.
  localparam int EW = ACC_W + 33;

  logic signed [EW-1:0] x_ext, rnd, y;

`ifdef TPU_SAT_EN
  localparam logic signed [EW-1:0] MAXV = EW'({(OUT_W-1){1'b1}});
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);
`endif

  always_comb begin
    x_ext = EW'($signed(acc_i));
    rnd   = (shift_i == 5'd0) ? '0 : (EW'(1) << (shift_i - 5'd1));
    y     = (x_ext + rnd) >>> shift_i;
`ifdef TPU_SAT_EN
    if (y > MAXV)      q_o = OUT_W'(MAXV);
    else if (y < MINV) q_o = OUT_W'(MINV);
    else               q_o = OUT_W'(y);
`else
    q_o = OUT_W'(y);
`endif
  end

endmodule

// File: rtl/tpu_mv_engine.sv
// Self-sequencing matrix-vector engine: K-deep signed dot products per tile,
// quantised (saturating when TPU_SAT_EN is defined) and written per tile.
module tpu_mv_engine
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE        = ARRAY_SIZE_DEF,
  parameter int DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int OUTPUT_DATA_WIDTH = OUT_WIDTH_DEF,
  parameter int K_MAX             = K_MAX_DEF,
  parameter int W_ADDR_WIDTH      = W_ADDR_W_DEF,
  parameter int V_ADDR_WIDTH      = V_ADDR_W_DEF,
  parameter int O_ADDR_WIDTH      = O_ADDR_W_DEF,
  localparam int ACC_WIDTH        = acc_width(DATA_WIDTH, K_MAX),
  localparam int KW               = $clog2(K_MAX + 1)
) (
  input  logic                                   clk,
  input  logic                                   srstn,
  input  logic                                   tpu_start,
  input  logic [KW-1:0]                          cfg_k_len,
  input  logic [O_ADDR_WIDTH-1:0]                cfg_tiles,
  input  logic [4:0]                             cfg_shift,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]       sram_rdata_w,
  input  logic [DATA_WIDTH-1:0]                  sram_rdata_v,
  output logic [W_ADDR_WIDTH-1:0]                sram_raddr_w,
  output logic [V_ADDR_WIDTH-1:0]                sram_raddr_v,
  output logic                                   sram_write_enable_a0,
  output logic [O_ADDR_WIDTH-1:0]                sram_waddr_a,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_wdata_a,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]        mul_outcome,
  output logic                                   tpu_busy,
  output logic                                   tpu_done
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [KW-1:0] KMAX_K = KW'(K_MAX);

  state_e                    state_q, state_d;
  logic [KW-1:0]             k_q, k_d, klen_q, klen_d;
  logic [O_ADDR_WIDTH-1:0]   t_q, t_d, tiles_q, tiles_d;
  logic [W_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [4:0]                shift_q, shift_d;
  logic                      vld_q;

  logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]         acc_q, acc_d;
  logic [ARRAY_SIZE-1:0][PW-1:0]                prod;
  logic [ARRAY_SIZE-1:0][OUTPUT_DATA_WIDTH-1:0] quant, wdata_q, wdata_d;

  logic [W_ADDR_WIDTH-1:0]   raddr_w_q, raddr_w_d;
  logic [V_ADDR_WIDTH-1:0]   raddr_v_q, raddr_v_d;
  logic                      we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [O_ADDR_WIDTH-1:0]   waddr_q, waddr_d;

  // Quantiser sees next-state accumulators so the registered write data
  // already includes the row absorbed during DRAIN.
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    assign prod[g] = PW'($signed(sram_rdata_w[g*DATA_WIDTH +: DATA_WIDTH])) *
                     PW'($signed(sram_rdata_v));
    tpu_mv_quantize #(
      .ACC_W (ACC_WIDTH),
      .OUT_W (OUTPUT_DATA_WIDTH)
    ) u_quant (
      .acc_i   (acc_d[g]),
      .shift_i (shift_q),
      .q_o     (quant[g])
    );
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    base_d  = base_q;
    klen_d  = klen_q;
    tiles_d = tiles_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: if (tpu_start) begin
        state_d = LOAD;
        k_d     = '0;
        t_d     = '0;
        base_d  = '0;
        klen_d  = (cfg_k_len == '0 || cfg_k_len > KMAX_K) ? KMAX_K : cfg_k_len;
        tiles_d = (cfg_tiles == '0) ? O_ADDR_WIDTH'(1) : cfg_tiles;
        shift_d = cfg_shift;
      end
      LOAD: if (k_q == klen_q - KW'(1)) begin
        k_d     = '0;
        state_d = DRAIN;
      end else begin
        k_d     = k_q + KW'(1);
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        t_d     = t_q + O_ADDR_WIDTH'(1);
        base_d  = base_q + W_ADDR_WIDTH'(klen_q);
        state_d = (t_q == tiles_q - O_ADDR_WIDTH'(1)) ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < ARRAY_SIZE; i++) begin
      acc_d[i] = acc_q[i];
      if (state_q == WRITE) acc_d[i] = '0;
      else if (vld_q)       acc_d[i] = acc_q[i] + ACC_WIDTH'($signed(prod[i]));
    end

    busy_d    = (state_d == LOAD) || (state_d == DRAIN) || (state_d == WRITE);
    done_d    = (state_d == DONE);
    raddr_w_d = (state_d == LOAD) ? base_d + W_ADDR_WIDTH'(k_d) : '0;
    raddr_v_d = (state_d == LOAD) ? V_ADDR_WIDTH'(k_d) : '0;
    we_d      = (state_d == WRITE);
    waddr_d   = we_d ? t_d : '0;
    wdata_d   = we_d ? quant : '0;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q   <= IDLE;
      k_q       <= '0;
      t_q       <= '0;
      base_q    <= '0;
      klen_q    <= '0;
      tiles_q   <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      acc_q     <= '0;
      raddr_w_q <= '0;
      raddr_v_q <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      t_q       <= t_d;
      base_q    <= base_d;
      klen_q    <= klen_d;
      tiles_q   <= tiles_d;
      shift_q   <= shift_d;
      vld_q     <= (state_q == LOAD);
      acc_q     <= acc_d;
      raddr_w_q <= raddr_w_d;
      raddr_v_q <= raddr_v_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sram_raddr_w         = raddr_w_q;
  assign sram_raddr_v         = raddr_v_q;
  assign sram_write_enable_a0 = we_q;
  assign sram_waddr_a         = waddr_q;
  assign sram_wdata_a         = wdata_q;
  assign mul_outcome          = acc_q;
  assign tpu_busy             = busy_q;
  assign tpu_done             = done_q;

endmodule

// File: tb/tb_tpu_mv_engine.sv
// Directed bench for tpu_mv_engine: table of single-tile jobs plus
// hand-written multi-tile, address-wrap and mid-run reset sequences.
module tb_tpu_mv_engine;

  localparam int AS = 8, DW = 8, OW = 16, KM = 8;
  localparam int WA = 6, VA = 5, OA = 6;
  localparam int AW = 2 * DW + $clog2(KM) + 1;

  logic clk = 1'b0, srstn = 1'b1, tpu_start = 1'b0;
  logic [3:0]       cfg_k_len = '0;
  logic [OA-1:0]    cfg_tiles = '0;
  logic [4:0]       cfg_shift = '0;
  logic [AS*DW-1:0] sram_rdata_w;
  logic [DW-1:0]    sram_rdata_v;
  logic [WA-1:0]    sram_raddr_w;
  logic [VA-1:0]    sram_raddr_v;
  logic             sram_write_enable_a0;
  logic [OA-1:0]    sram_waddr_a;
  logic [AS*OW-1:0] sram_wdata_a;
  logic [AS*AW-1:0] mul_outcome;
  logic             tpu_busy, tpu_done;

  tpu_mv_engine dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start),
    .cfg_k_len(cfg_k_len), .cfg_tiles(cfg_tiles), .cfg_shift(cfg_shift),
    .sram_rdata_w(sram_rdata_w), .sram_rdata_v(sram_rdata_v),
    .sram_raddr_w(sram_raddr_w), .sram_raddr_v(sram_raddr_v),
    .sram_write_enable_a0(sram_write_enable_a0), .sram_waddr_a(sram_waddr_a),
    .sram_wdata_a(sram_wdata_a), .mul_outcome(mul_outcome),
    .tpu_busy(tpu_busy), .tpu_done(tpu_done)
  );

  always #5 clk = ~clk;

  logic [AS*DW-1:0] wmem [64];
  logic [DW-1:0]    vmem [32];

  // Synchronous-read SRAM models: data one cycle after the address.
  always @(posedge clk) begin
    sram_rdata_w <= wmem[sram_raddr_w];
    sram_rdata_v <= vmem[sram_raddr_v];
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]           k;
    logic [OA-1:0]        tiles;
    logic [4:0]           sh;
    int                   ke;
    logic signed [DW-1:0] w0, w1, wr, v;
    logic signed [OW-1:0] e0, e1, er;
    int                   eacc0;
  } vec_t;

  int               wr_cyc[$];
  int               wr_addr[$];
  logic [AS*OW-1:0] wr_data[$];
  logic [AS*AW-1:0] wr_acc[$];
  int               done_cyc, addr_err, busy_err, idle_err;

  task automatic load_uniform(input logic signed [DW-1:0] w0, w1, wr, v);
    logic [AS*DW-1:0] row;
    row = '0;
    for (int i = 0; i < AS; i++) row[i*DW +: DW] = (i == 0) ? w0 : (i == 1) ? w1 : wr;
    for (int a = 0; a < 64; a++) wmem[a] = row;
    for (int a = 0; a < 32; a++) vmem[a] = v;
  endtask

  task automatic load_ramp();
    logic [AS*DW-1:0] row;
    for (int a = 0; a < 64; a++) begin
      for (int i = 0; i < AS; i++) row[i*DW +: DW] = DW'(a);
      wmem[a] = row;
    end
    for (int a = 0; a < 32; a++) vmem[a] = DW'(1);
  endtask

  // Runs one job from an accepted start; cycle c is sampled at its negedge.
  task automatic run_job(input logic [3:0] k, input logic [OA-1:0] tiles,
                         input logic [4:0] sh, input int ke, input int te,
                         input int xs, input string nm);
    int pos, tt, ew, ev;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_acc.delete();
    done_cyc = -1; addr_err = 0; busy_err = 0; idle_err = 0;
    @(negedge clk);
    cfg_k_len = k; cfg_tiles = tiles; cfg_shift = sh; tpu_start = 1'b1;
    for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
      @(negedge clk);
      tpu_start = (c == xs);
      pos = (c - 1) % (ke + 2);
      tt  = (c - 1) / (ke + 2);
      if (c <= te * (ke + 2) && pos < ke) begin
        ew = (tt * ke + pos) % 64; ev = pos;
      end else begin
        ew = 0; ev = 0;
      end
      if (int'(sram_raddr_w) != ew || int'(sram_raddr_v) != ev) addr_err++;
      if (c <= te * (ke + 2) && (tpu_busy !== 1'b1 || tpu_done !== 1'b0)) busy_err++;
      if (sram_write_enable_a0 === 1'b1) begin
        wr_cyc.push_back(c); wr_addr.push_back(int'(sram_waddr_a));
        wr_data.push_back(sram_wdata_a); wr_acc.push_back(mul_outcome);
      end else if (sram_waddr_a !== '0 || sram_wdata_a !== '0) idle_err++;
      if (tpu_done === 1'b1) begin
        done_cyc = c;
        if (tpu_busy !== 1'b0) busy_err++;
      end
    end
    tpu_start = 1'b0;
    chk({nm, "_addr_seq"}, addr_err, 0);
    chk({nm, "_busy"}, busy_err, 0);
    chk({nm, "_idle_wr"}, idle_err, 0);
    chk({nm, "_done_cyc"}, done_cyc, te * (ke + 2) + 1);
    chk({nm, "_n_writes"}, wr_cyc.size(), te);
  endtask

  function automatic logic signed [63:0] lane(input logic [AS*OW-1:0] d, input int i);
    return 64'($signed(d[i*OW +: OW]));
  endfunction

  vec_t tbl[7];

  initial begin
    logic [AS*OW-1:0] d;
    logic [AS*AW-1:0] a;
    int seen;
    string nm;

`ifdef TPU_SAT_EN
    localparam logic signed [OW-1:0] SAT_POS = 16'sd32767, SAT_NEG = -16'sd32768;
`else
    localparam logic signed [OW-1:0] SAT_POS = 16'sd0, SAT_NEG = 16'sd1024;
`endif
    //          k     tiles  sh     ke  w0        w1        wr        v          e0          e1          er          eacc0
    tbl[0] = '{4'd1, 6'd1, 5'd0, 1, 8'sd1,    8'sd1,    8'sd1,    8'sd5,     16'sd5,     16'sd5,     16'sd5,     5};
    tbl[1] = '{4'd8, 6'd1, 5'd0, 8, -8'sd128, -8'sd128, -8'sd128, -8'sd128,  SAT_POS,    SAT_POS,    SAT_POS,    131072};
    tbl[2] = '{4'd1, 6'd1, 5'd1, 1, 8'sd1,    -8'sd1,   8'sd0,    8'sd3,     16'sd2,     -16'sd1,    16'sd0,     3};
    tbl[3] = '{4'd0, 6'd0, 5'd0, 8, 8'sd1,    8'sd1,    8'sd1,    8'sd2,     16'sd16,    16'sd16,    16'sd16,    16};
    tbl[4] = '{4'd9, 6'd1, 5'd2, 8, 8'sd2,    8'sd2,    8'sd2,    -8'sd3,    -16'sd12,   -16'sd12,   -16'sd12,   -48};
    tbl[5] = '{4'd2, 6'd1, 5'd3, 2, 8'sd100,  -8'sd100, 8'sd0,    8'sd100,   16'sd2500,  -16'sd2500, 16'sd0,     20000};
    tbl[6] = '{4'd8, 6'd1, 5'd0, 8, -8'sd128, -8'sd128, -8'sd128, 8'sd127,   SAT_NEG,    SAT_NEG,    SAT_NEG,    -130048};

    load_uniform(8'sd0, 8'sd0, 8'sd0, 8'sd0);
    #2 srstn = 1'b0;
    #1 chk("reset_outputs", 64'(|{sram_raddr_w, sram_raddr_v, sram_write_enable_a0,
           sram_waddr_a, sram_wdata_a, mul_outcome, tpu_busy, tpu_done}), 0);
    repeat (2) @(negedge clk);
    srstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("vec%0d", i);
      load_uniform(tbl[i].w0, tbl[i].w1, tbl[i].wr, tbl[i].v);
      run_job(tbl[i].k, tbl[i].tiles, tbl[i].sh, tbl[i].ke, 1, -1, nm);
      if (wr_cyc.size() > 0) begin
        d = wr_data[0]; a = wr_acc[0];
        chk({nm, "_wr_cyc"}, wr_cyc[0], tbl[i].ke + 2);
        chk({nm, "_waddr"}, wr_addr[0], 0);
        chk({nm, "_lane0"}, lane(d, 0), 64'(tbl[i].e0));
        chk({nm, "_lane1"}, lane(d, 1), 64'(tbl[i].e1));
        chk({nm, "_lane7"}, lane(d, 7), 64'(tbl[i].er));
        chk({nm, "_acc0"}, 64'($signed(a[AW-1:0])), 64'(tbl[i].eacc0));
      end
    end

    // Three tiles of depth 4 over a ramp; stray start during tile 0 DRAIN.
    load_ramp();
    run_job(4'd4, 6'd3, 5'd0, 4, 3, 5, "multi");
    for (int t = 0; t < 3 && t < wr_cyc.size(); t++) begin
      nm = $sformatf("multi_t%0d", t);
      chk({nm, "_cyc"}, wr_cyc[t], 6 * (t + 1));
      chk({nm, "_waddr"}, wr_addr[t], t);
      chk({nm, "_lane3"}, lane(wr_data[t], 3), 16 * t + 6);
    end

    // Nine tiles of depth 8 walk past the weight address space and wrap.
    run_job(4'd8, 6'd9, 5'd0, 8, 9, -1, "wrap");
    if (wr_cyc.size() == 9) begin
      chk("wrap_last_waddr", wr_addr[8], 8);
      chk("wrap_last_lane5", lane(wr_data[8], 5), 28);
    end

    // Reset in cycle 3 of a run drops everything and never pulses done.
    load_uniform(8'sd3, 8'sd3, 8'sd3, 8'sd2);
    @(negedge clk);
    cfg_k_len = 4'd4; cfg_tiles = 6'd1; cfg_shift = 5'd0; tpu_start = 1'b1;
    @(negedge clk); tpu_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_acc0", 64'($signed(mul_outcome[AW-1:0])), 6);
    srstn = 1'b0;
    #1 chk("mid_rst_outputs", 64'(|{sram_raddr_w, sram_raddr_v, sram_write_enable_a0,
           sram_waddr_a, sram_wdata_a, mul_outcome, tpu_busy, tpu_done}), 0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (tpu_done !== 1'b0) seen++; end
    srstn = 1'b1;
    repeat (12) begin @(negedge clk); if (tpu_done !== 1'b0 || tpu_busy !== 1'b0) seen++; end
    chk("no_done_after_rst", seen, 0);
    run_job(4'd4, 6'd1, 5'd0, 4, 1, -1, "post_rst");
    if (wr_cyc.size() > 0) chk("post_rst_lane6", lane(wr_data[0], 6), 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_mv_engine.md
# tpu_mv_engine

Parametrised matrix-vector engine, next generation of the co-accelerator top. It fetches a weight row (ARRAY_SIZE lanes) and one vector element per cycle, and accumulates ARRAY_SIZE signed dot products over a runtime-selectable depth. It quantises each tile's results and writes them to the output SRAM, repeating for a runtime-selectable tile count. It replaces the fixed-K, fixed-data-set controller/datapath split with one self-sequencing block driven by a start/busy/done handshake.

## Interface
- ARRAY_SIZE, 8: lanes (rows per tile)
- DATA_WIDTH, 8: signed weight/vector element width
- OUTPUT_DATA_WIDTH, 16: signed quantised output width per lane
- K_MAX, 8: maximum accumulation depth
- W_ADDR_WIDTH, 6 / V_ADDR_WIDTH, 5 / O_ADDR_WIDTH, 6: SRAM address widths
- clk  in  1  clock; one clock domain
- srstn  in  1  reset, asynchronous, active-low
- tpu_start  in  1  start request, sampled in IDLE only
- cfg_k_len  in  $clog2(K_MAX+1)  depth; 0 or >K_MAX → K_MAX
- cfg_tiles  in  O_ADDR_WIDTH  tile count; 0 → 1
- cfg_shift  in  5  quantisation right-shift
- sram_rdata_w  in  ARRAY_SIZE*DATA_WIDTH  weight row; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- sram_rdata_v  in  DATA_WIDTH  vector element
- sram_raddr_w  out  W_ADDR_WIDTH  weight address
- sram_raddr_v  out  V_ADDR_WIDTH  vector address
- sram_write_enable_a0  out  1  output write strobe
- sram_waddr_a  out  O_ADDR_WIDTH  output address
- sram_wdata_a  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  quantised lanes
- mul_outcome  out  ARRAY_SIZE*ACC_WIDTH  live accumulators
- tpu_busy  out  1  high from the cycle after start until done
- tpu_done  out  1  one-cycle completion pulse
- All outputs reset to 0.

## Operation
- ACC_WIDTH = 2*DATA_WIDTH + $clog2(K_MAX) + 1.
- Signed multiply, sign-extended accumulate.
- Config is latched on accepted start.
- FSM: IDLE → LOAD → DRAIN → WRITE → (LOAD if tiles remain, else DONE) → IDLE.
- IDLE: tpu_start=1 latches config and clears counters k=0, t=0.
- LOAD, K cycles: sram_raddr_w = (t*K + k) mod 2^W_ADDR_WIDTH; sram_raddr_v = k.
- Data returns one cycle after the address (sync SRAM). A 1-bit valid pipe gates the accumulate: acc[i] += w[i]*v.
- DRAIN, 1 cycle: absorbs the last returned row.
- WRITE, 1 cycle: strobe=1, waddr=t, wdata=quant(acc). Accumulators clear at the end of the cycle; t increments.
- DONE, 1 cycle: tpu_done=1, busy=0.
- quant(x): if shift>0, y = (x + 2^(shift-1)) >>> shift, else y = x. y is then saturated to the signed OUTPUT_DATA_WIDTH range, or truncated (see Configuration).
- tpu_start while busy is ignored.
- A reset mid-operation returns to IDLE, zeroes accumulators and outputs, and loses the run; no done pulse.

## Timing
- Start sampled at cycle 0. LOAD occupies cycles 1..K, DRAIN K+1, WRITE K+2. Each tile costs K+2 cycles.
- Tile t WRITE at cycle (t+1)*(K+2).
- tpu_done at cycle T*(K+2)+1; a new start is accepted from the cycle after done.
- Addresses and write signals are registered; mul_outcome is a direct accumulator register view.
- Outside LOAD, raddr holds 0. Outside WRITE, waddr/wdata hold 0.

## Configuration
- TPU_SAT_EN defined: quantiser saturates to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1].
- TPU_SAT_EN undefined: quantiser keeps the low OUTPUT_DATA_WIDTH bits (two's-complement wrap).
- Rounding is identical in both builds.

## Structure
- tpu_pkg: state enum (IDLE, LOAD, DRAIN, WRITE, DONE), acc_width(data_w, k_max) function, default width constants.
- Sub-module tpu_mv_quantize: one lane, combinational round/shift/saturate, instantiated ARRAY_SIZE times by generate.

## Test plan
Defaults: ARRAY_SIZE=8, DATA_WIDTH=8, OUTPUT_DATA_WIDTH=16, K_MAX=8.
- K=1, T=1, shift 0, all w=1, v=5 → single write waddr 0, every lane 5, write at cycle 3, done at 4.
- K=8, w=-128, v=-128 every step → acc 131072. With TPU_SAT_EN, wdata lanes 32767; without, lanes 0.
- Rounding, K=1, shift 1: lane0 w=1, v=3 → 2; lane1 w=-1, v=3 → -1.
- K=4, T=3 → raddr_w sequence 0..11, writes waddr 0/1/2 at cycles 6/12/18, done at 19; start pulsed at cycle 5 has no effect.
- cfg_k_len=0 → eight LOAD cycles (K_MAX). cfg_tiles=0 → exactly one write.
- srstn low at cycle 3 of a run → all outputs 0 immediately, no done. A following start completes normally with correct values.
